// File: rtl/pcm_stream_dac.sv
// pcm_stream_dac
//
// Paced playback path from the sample FIFO to the audio pins. A programmable
// rate divider issues one tick per sample period. On each tick a whole frame
// (one word for mono or mono_dup, L then R for stereo) is fetched from the
// FIFO, or, if the FIFO holds less than a full frame, the outputs fall back
// to offset-binary midscale and the underrun counter advances. Each channel
// drives a first-order delta-sigma bitstream from its current sample.
//
// Ports:
//   clk           system clock (96 MHz)
//   rst_n         asynchronous active-low reset
//   enable        playback enable; low forces midscale and stops reads
//   mono_dup      stereo build only: one word per frame, copied to both channels
//   rate_div      tick period minus one (values below 7 behave as 7)
//   fifo_level    current FIFO word count
//   fifo_rd_en    FIFO read strobe; fifo_dout is valid on the next cycle
//   fifo_dout     FIFO read data
//   underrun_clr  synchronous clear of underrun_cnt
//   underrun_cnt  saturating underrun count
//   busy          frame fetch in progress
//   sample_out    samples currently played, channel 0 in the LSBs
//   dac_out       delta-sigma bitstreams, one per channel

module pcm_stream_dac #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 16,
  parameter int DIV_W    = 12,
  parameter int LEVEL_W  = 9,
  parameter int UCNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         mono_dup,
  input  logic [DIV_W-1:0]             rate_div,
  input  logic [LEVEL_W-1:0]           fifo_level,
  output logic                         fifo_rd_en,
  input  logic [SAMPLE_W-1:0]          fifo_dout,
  input  logic                         underrun_clr,
  output logic [UCNT_W-1:0]            underrun_cnt,
  output logic                         busy,
  output logic [CHANNELS*SAMPLE_W-1:0] sample_out,
  output logic [CHANNELS-1:0]          dac_out
);

  localparam logic [DIV_W-1:0]             MIN_DIV   = DIV_W'(7);
  localparam logic [SAMPLE_W-1:0]          MIDSCALE  = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [CHANNELS*SAMPLE_W-1:0] MID_FRAME = {CHANNELS{MIDSCALE}};
  localparam logic [LEVEL_W-1:0]           ONE_WORD  = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0]           TWO_WORDS = LEVEL_W'(2);
  localparam logic [UCNT_W-1:0]            UCNT_MAX  = {UCNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    CAP0,
    CAP1,
    UPD
  } fetch_state_t;

  fetch_state_t                state;
  fetch_state_t                state_nx;
  logic [DIV_W-1:0]            div_eff;
  logic [DIV_W-1:0]            tick_cnt;
  logic                        tick;
  logic                        want_two;
  logic                        have_frame;
  logic                        start_fetch;
  logic                        underrun;
  logic                        two_words;
  logic [SAMPLE_W-1:0]         word0;
  logic [CHANNELS*SAMPLE_W-1:0] stereo_frame;

  // The clamp keeps the tick period at 8 cycles or more, which is longer
  // than the 5-cycle stereo fetch, so a tick can never land mid-fetch.
  assign div_eff = (rate_div < MIN_DIV) ? MIN_DIV : rate_div;

  // >= rather than == so that lowering rate_div below the running count
  // produces a tick right away instead of a full counter wrap.
  assign tick = enable && (tick_cnt >= div_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + DIV_W'(1);
    end
  end

  // Frame size is decided at the tick; a partial frame is never read.
  assign want_two    = (CHANNELS == 2) && !mono_dup;
  assign have_frame  = fifo_level >= (want_two ? TWO_WORDS : ONE_WORD);
  assign start_fetch = tick && (state == IDLE) && have_frame;
  assign underrun    = tick && (state == IDLE) && !have_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Once RD0 is entered the fetch always runs to UPD, regardless of
  // enable, so a committed read is never abandoned and frames stay whole.
  always_comb begin
    state_nx   = state;
    fifo_rd_en = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_fetch) begin
          state_nx = RD0;
        end
      end
      RD0: begin
        fifo_rd_en = 1'b1;
        state_nx   = CAP0;
      end
      CAP0: begin
        fifo_rd_en = two_words;
        state_nx   = two_words ? CAP1 : UPD;
      end
      CAP1: begin
        state_nx = UPD;
      end
      UPD: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Right channel(s) take the word arriving now, channel 0 the held word.
  always_comb begin
    stereo_frame               = {CHANNELS{fifo_dout}};
    stereo_frame[SAMPLE_W-1:0] = word0;
  end

  // sample_out is loaded on the edge that enters UPD, so the new frame is
  // visible during UPD. Midscale is loaded only from IDLE or UPD, which
  // lets a fetch that outlives enable still show its frame for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out <= MID_FRAME;
      word0      <= '0;
      two_words  <= 1'b0;
    end else begin
      if (start_fetch) begin
        two_words <= want_two;
      end
      case (state)
        CAP0: begin
          if (two_words) begin
            word0 <= fifo_dout;
          end else begin
            sample_out <= {CHANNELS{fifo_dout}};
          end
        end
        CAP1: begin
          sample_out <= stereo_frame;
        end
        IDLE, UPD: begin
          if (underrun || !enable) begin
            sample_out <= MID_FRAME;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (underrun_clr) begin
      underrun_cnt <= '0;
    end else if (underrun && (underrun_cnt != UCNT_MAX)) begin
      underrun_cnt <= underrun_cnt + UCNT_W'(1);
    end
  end

  // First-order delta-sigma: the carry out of the accumulator is the
  // output bit, so its density equals sample / 2^SAMPLE_W.
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_dsm
    logic [SAMPLE_W:0] acc;
    logic              dsm_bit;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc     <= '0;
        dsm_bit <= 1'b0;
      end else begin
        acc     <= {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, sample_out[ch*SAMPLE_W +: SAMPLE_W]};
        dsm_bit <= acc[SAMPLE_W];
      end
    end

    assign dac_out[ch] = dsm_bit;
  end

endmodule
